// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
//   - uart_state_e : transmitter FSM state encoding
//   - OVERSAMPLE   : clocks per prescale unit (bit period = OVERSAMPLE * prescale)
// Build option: UART_TX_BUF_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_BUF_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO with show-ahead read data.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata (ignored while full, even if pop is also high)
//   pop      : drop the head entry (ignored while empty)
//   wdata    : write data
//   rdata    : current head entry (valid while !empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, $clog2(DEPTH)+1 bits
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Fullness is judged before this edge's pop, so a pop never makes room
  // for a push in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: UART transmitter with an input FIFO.
// Frame: start bit (0), DATA_WIDTH_P data bits LSB first, optional even
// parity bit, STOP_BITS_P stop bits (1). Each bit lasts 8*max(prescale,1)
// clocks, with prescale latched when the frame starts.
// Build option: define UART_TX_BUF_PARITY_EN to send the parity bit.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   data_i       : word to transmit
//   valid_i      : data_i is valid
//   ready_o      : FIFO can accept a word
//   prescale_i   : bit period = 8*prescale_i clocks (0 treated as 1)
//   tx_o         : serial line, idle high
//   busy_o       : a frame is in progress
//   count_o      : FIFO occupancy
//   state_o      : FSM state, for observation
//
// Handshake: a word is taken on every rising edge where valid_i and ready_o
// are both 1; ready_o depends only on FIFO occupancy, never on valid_i.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH_P = 8,
  parameter int DEPTH_P      = 4,
  parameter int STOP_BITS_P  = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_P-1:0]   data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [15:0]               prescale_i,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [$clog2(DEPTH_P):0]  count_o,
  output logic [2:0]                state_o
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH_P - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS_P - 1);

  uart_state_e             state;
  logic [15:0]             presc_q;
  logic [18:0]             clk_cnt;
  logic [18:0]             bit_len;
  logic                    bit_end;
  logic [3:0]              bit_idx;
  logic [DATA_WIDTH_P-1:0] shreg;
  logic [DATA_WIDTH_P-1:0] fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
`ifdef UART_TX_BUF_PARITY_EN
  logic                    parity_q;
`endif

  uart_fifo #(
    .WIDTH (DATA_WIDTH_P),
    .DEPTH (DEPTH_P)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (valid_i),
    .pop   (fifo_pop),
    .wdata (data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_o)
  );

  assign ready_o = !fifo_full;
  assign state_o = state;
  assign bit_len = 19'(presc_q) * 19'(OVERSAMPLE);
  assign bit_end = (clk_cnt == bit_len - 19'd1);

  // A new frame is loaded either from IDLE or on the last clock of the final
  // stop bit, which gives back-to-back frames without an idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) ||
                     (state == STOP && bit_end && bit_idx == LAST_STOP));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      presc_q <= '0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_BUF_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_o    <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 19'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_TX_BUF_PARITY_EN
              tx_o    <= parity_q;
              state   <= PARITY;
`else
              tx_o    <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              // Shift first, so shreg[1] is the next bit to go out.
              bit_idx <= bit_idx + 4'd1;
              shreg   <= shreg >> 1;
              tx_o    <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 19'd1;
          end
        end
`ifdef UART_TX_BUF_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 19'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              tx_o   <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 19'd1;
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Frame load overrides whatever the case above scheduled.
      if (fifo_pop) begin
        state   <= START;
        tx_o    <= 1'b0;
        busy_o  <= 1'b1;
        shreg   <= fifo_rdata;
        presc_q <= (prescale_i == 16'd0) ? 16'd1 : prescale_i;
        clk_cnt <= '0;
        bit_idx <= '0;
`ifdef UART_TX_BUF_PARITY_EN
        parity_q <= ^fifo_rdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: self-checking bench for uart_tx_buf (default parameters).
// A timestamp-based reference model predicts tx_o, busy_o, ready_o and
// count_o for every clock; directed steps add frame-length, peak-occupancy,
// stall and reset checks. Honours UART_TX_BUF_PARITY_EN like the design.
module tb_uart_tx_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int STOPB = 1;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_BUF_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 1 + DW + PAR + STOPB;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [15:0]   prescale_i;
  logic          tx_o;
  logic          busy_o;
  logic [CW-1:0] count_o;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  uart_tx_buf #(
    .DATA_WIDTH_P (DW),
    .DEPTH_P      (DEPTH),
    .STOP_BITS_P  (STOPB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .prescale_i (prescale_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .state_o    (state_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Words wait in exp_q; a frame occupies the line for NB bit periods from
  // the edge it is popped. A pop happens on any edge at or after the end of
  // the previous frame when a word is waiting.
  logic [DW-1:0] exp_q[$];
  bit            m_on = 1'b0;
  longint        e = 0;
  longint        m_start = 0;
  longint        m_busy_until = 0;
  int            m_bitlen = 8;
  logic [DW-1:0] m_word = '0;
  logic          exp_tx = 1'b1;
  logic          exp_busy = 1'b0;
  int            exp_count = 0;

  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (PAR == 1 && k == DW + 1) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      e = 0;
      m_start = 0;
      m_busy_until = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      bit was_full;
      was_full = (exp_q.size() >= DEPTH);
      e++;
      if (e >= m_busy_until && exp_q.size() > 0) begin
        m_word       = exp_q.pop_front();
        m_bitlen     = 8 * ((prescale_i == 16'd0) ? 1 : int'(prescale_i));
        m_start      = e;
        m_busy_until = e + NB * m_bitlen;
      end
      if (valid_i && !was_full) exp_q.push_back(data_i);
    end
    if (m_on) begin
      exp_busy  = (e < m_busy_until);
      exp_tx    = exp_busy ? frame_bit(m_word, int'((e - m_start) / m_bitlen)) : 1'b1;
      exp_count = exp_q.size();
    end
  end

  // ---------------- scoreboard: per-cycle line check ----------------
  int run_len = 0;
  int busy_runs[$];

  always @(negedge clk) begin
    if (m_on) begin
      logic [CW+2:0] obs;
      logic [CW+2:0] expv;
      obs  = {tx_o, busy_o, ready_o, count_o};
      expv = {exp_tx, exp_busy, (exp_count < DEPTH), CW'(exp_count)};
      tests_run++;
      assert (obs === expv) else begin
        tests_failed++;
        $error("FAIL line_state cycle %0d observed tx,busy,ready,count=%b required %b", e, obs, expv);
      end
      if (busy_o === 1'b1) run_len++;
      else if (run_len > 0) begin
        busy_runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  function automatic int run_at(input int i);
    return (i < busy_runs.size()) ? busy_runs[i] : -1;
  endfunction

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  int seen_max_count = 0;
  bit seen_busy = 1'b0;
  bit seen_tx_low = 1'b0;
  int stalls = 0;

  task automatic idle_cycles(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      if (int'(count_o) > seen_max_count) seen_max_count = int'(count_o);
      if (busy_o === 1'b1) seen_busy = 1'b1;
      if (tx_o === 1'b0) seen_tx_low = 1'b1;
      @(negedge clk);
    end
  endtask

  // Holds valid_i with the word until ready_o lets it in; valid_i stays high
  // on return so consecutive calls push on consecutive edges.
  task automatic push_word(input logic [DW-1:0] w);
    int waited;
    waited  = 0;
    data_i  = w;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && waited < 2000) begin
      stalls++;
      check("stall_count_full", count_o, DEPTH);
      waited++;
      @(negedge clk);
    end
    if (waited >= 2000) begin
      tests_run++;
      tests_failed++;
      $error("FAIL push_timeout observed ready=%b for %0d cycles required 1", ready_o, waited);
    end
    if (int'(count_o) > seen_max_count) seen_max_count = int'(count_o);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h99;
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int idx;
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    data_i     = '0;
    prescale_i = 16'd1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    check("reset_tx", tx_o, 1);
    check("reset_busy", busy_o, 0);
    check("reset_ready", ready_o, 1);
    check("reset_count", count_o, 0);

    // Single frame 0x55 at prescale 1.
    idx = busy_runs.size();
    push_word(8'h55);
    idle_cycles(110);
    check("frame55_len", run_at(idx), NB * 8);
    check("frame55_runs", busy_runs.size(), idx + 1);

    // 0x07: parity bit is 1 when enabled, frame length follows NB.
    idx = busy_runs.size();
    push_word(8'h07);
    idle_cycles(110);
    check("frame07_len", run_at(idx), NB * 8);

    // Three words back to back: one contiguous busy stretch, peak count 2.
    idx = busy_runs.size();
    seen_max_count = 0;
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    idle_cycles(3 * NB * 8 + 30);
    check("b2b_len", run_at(idx), 3 * NB * 8);
    check("b2b_peak_count", seen_max_count, 2);

    // Overfill while a frame is running: ready_o drops at 4, nothing lost.
    idx = busy_runs.size();
    push_word(8'h11);
    idle_cycles(3);
    stalls = 0;
    for (int i = 0; i < 6; i++) push_word(8'h20 + 8'(i));
    idle_cycles(7 * NB * 8 + 30);
    check("overfill_stalled", (stalls > 0) ? 1 : 0, 1);
    check("overfill_len", run_at(idx), 7 * NB * 8);

    // Reset 30 clocks into a frame with words pending; push during reset.
    push_word(8'h5A);
    push_word(8'h33);
    push_word(8'h0F);
    idle_cycles(28);
    pulse_reset();
    check("midreset_tx", tx_o, 1);
    check("midreset_busy", busy_o, 0);
    check("midreset_count", count_o, 0);
    check("midreset_ready", ready_o, 1);
    seen_busy   = 1'b0;
    seen_tx_low = 1'b0;
    idle_cycles(300);
    check("midreset_no_resume", seen_busy, 0);
    check("midreset_line_high", seen_tx_low, 0);

    // Prescale change mid-frame affects only the next frame.
    idx = busy_runs.size();
    prescale_i = 16'd1;
    push_word(8'h3C);
    idle_cycles(20);
    prescale_i = 16'd2;
    idle_cycles(100);
    push_word(8'hA5);
    idle_cycles(NB * 16 + 30);
    check("presc_frame1_len", run_at(idx), NB * 8);
    check("presc_frame2_len", run_at(idx + 1), NB * 16);

    // Random words, gaps and prescale values (0..3), one reset in the middle.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) prescale_i = 16'($urandom_range(0, 3));
      push_word(DW'($urandom));
      if (i == 20) pulse_reset();
      idle_cycles($urandom_range(0, 40));
    end
    idle_cycles(6 * NB * 24 + 50);
    check("drain_busy", busy_o, 0);
    check("drain_count", count_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
